// File: rtl/frame_pixel_unpacker_pkg.sv
// frame_pixel_unpacker_pkg
// Shared types and elaboration helpers for the pixel unpacker and its output slice.
//   calc_ppb       : pixels carried by one input beat (STREAM_WIDTH / PIXEL_WIDTH).
//   calc_idx_width : width of an index that counts 0..n-1, never narrower than 1 bit.
//   frame_event_e  : what the pixel currently leaving the beat register does to the frame.
package frame_pixel_unpacker_pkg;

    // EvAdvance     : ordinary pixel inside a frame.
    // EvFrameEnd    : last pixel of the frame count, arriving on a tlast beat.
    // EvMissingLast : frame count ends but the beat carries no tlast.
    // EvEarlyLast   : tlast beat ends before the frame count does.
    typedef enum logic [1:0] {
        EvAdvance,
        EvFrameEnd,
        EvMissingLast,
        EvEarlyLast
    } frame_event_e;

    function automatic int unsigned calc_ppb(input int unsigned stream_width,
                                             input int unsigned pixel_width);
        return stream_width / pixel_width;
    endfunction

    function automatic int unsigned calc_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_pixel_unpacker_axis_output_register.sv
// frame_pixel_unpacker_axis_output_register
// One-entry AXI-Stream register slice carrying data plus tuser/tlast sideband.
// It accepts a new entry whenever it is empty or its current entry is being consumed,
// so it sustains one transfer per cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake
//   in_data/user/last : upstream payload
//   out_valid/ready   : downstream handshake
//   out_data/user/last: registered payload, held stable while stalled
module frame_pixel_unpacker_axis_output_register #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_user,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_user,
    output logic                  out_last
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_user  <= in_user;
            out_last  <= in_last;
        end else if (out_ready) begin
            // Payload is kept; only the valid flag drops once the entry is taken.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_pixel_unpacker.sv
// frame_pixel_unpacker
// Splits wide AXI-Stream beats (PPB pixels each, pixel 0 in the LSBs) into one pixel per
// output beat. Output tuser marks the first pixel of a frame and tlast the last pixel of a
// line, both derived from internal x/y counters. A frame-length disagreement with the
// input tlast raises a one-cycle frameError alongside the offending pixel.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   s_axis_tvalid/tready       : input beat handshake
//   s_axis_tlast, s_axis_tdata : input end-of-frame marker and packed pixels
//   m_axis_tvalid/tready       : output pixel handshake
//   m_axis_tlast, m_axis_tuser : end-of-line, start-of-frame
//   m_axis_tdata               : output pixel
//   frameError                 : pulse with the first presentation of a mismatching pixel
// X_RESOLUTION must be a multiple of PPB and STREAM_WIDTH a multiple of PIXEL_WIDTH.
module frame_pixel_unpacker
    import frame_pixel_unpacker_pkg::*;
#(
    parameter int unsigned STREAM_WIDTH = 16,
    parameter int unsigned PIXEL_WIDTH  = 16,
    parameter int unsigned X_RESOLUTION = 128,
    parameter int unsigned Y_RESOLUTION = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [PIXEL_WIDTH-1:0]  m_axis_tdata,
    output logic                    frameError
);

    localparam int unsigned PPB    = calc_ppb(STREAM_WIDTH, PIXEL_WIDTH);
    localparam int unsigned SLOT_W = calc_idx_width(PPB);
    localparam int unsigned X_W    = calc_idx_width(X_RESOLUTION);
    localparam int unsigned Y_W    = calc_idx_width(Y_RESOLUTION);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPB - 1);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(X_RESOLUTION - 1);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(Y_RESOLUTION - 1);

    // Beat register
    logic [STREAM_WIDTH-1:0] beat_data;
    logic                    beat_valid;
    logic                    beat_last;
    logic [SLOT_W-1:0]       slot;

    // Frame position of the pixel at the current slot
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;

    logic                   out_in_ready;
    logic                   pix_move;
    logic                   last_slot;
    logic                   s_fire;
    logic [31:0]            pix_base;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_user;
    logic                   pix_last;
    logic                   pix_error;
    frame_event_e           pix_event;

    // A pixel leaves the beat register whenever the output slice can take it.
    assign pix_move  = beat_valid && out_in_ready;
    assign last_slot = (slot == LAST_SLOT);
    assign s_fire    = s_axis_tvalid && s_axis_tready;

    // Refill on the same cycle the last slot drains, so beats run back-to-back.
    assign s_axis_tready = !beat_valid || (last_slot && pix_move);

    assign pix_base = 32'(slot) * PIXEL_WIDTH;
    assign pix_data = beat_data[pix_base +: PIXEL_WIDTH];

    always_comb begin
        pix_event = EvAdvance;
        if ((x_cnt == X_MAX) && (y_cnt == Y_MAX)) begin
            pix_event = (last_slot && beat_last) ? EvFrameEnd : EvMissingLast;
        end else if (last_slot && beat_last) begin
            pix_event = EvEarlyLast;
        end
    end

    assign pix_user  = (x_cnt == '0) && (y_cnt == '0);
    // An early tlast still closes the line so downstream sees a clean boundary.
    assign pix_last  = (x_cnt == X_MAX) || (pix_event == EvEarlyLast);
    assign pix_error = (pix_event == EvMissingLast) || (pix_event == EvEarlyLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_data  <= '0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            slot       <= '0;
        end else if (s_fire) begin
            beat_data  <= s_axis_tdata;
            beat_valid <= 1'b1;
            beat_last  <= s_axis_tlast;
            slot       <= '0;
        end else if (pix_move) begin
            if (last_slot) begin
                beat_valid <= 1'b0;
                slot       <= '0;
            end else begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_move) begin
            unique case (pix_event)
                EvAdvance: begin
                    if (x_cnt == X_MAX) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + Y_W'(1);
                    end else begin
                        x_cnt <= x_cnt + X_W'(1);
                    end
                end
                EvFrameEnd, EvMissingLast, EvEarlyLast: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end
                default: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end
            endcase
        end
    end

    // Loaded together with the pixel, so it coincides with its first presentation and
    // drops on the next cycle even if that pixel is still stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            frameError <= 1'b0;
        end else begin
            frameError <= pix_move && pix_error;
        end
    end

    frame_pixel_unpacker_axis_output_register #(
        .DATA_WIDTH(PIXEL_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (beat_valid),
        .in_ready (out_in_ready),
        .in_data  (pix_data),
        .in_user  (pix_user),
        .in_last  (pix_last),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_data (m_axis_tdata),
        .out_user (m_axis_tuser),
        .out_last (m_axis_tlast)
    );

endmodule

// File: doc/frame_pixel_unpacker.md
# frame_pixel_unpacker

Downstream neighbour of the framebuffer commit stream. It accepts wide AXIS beats, each packing several pixels, and emits one pixel per beat on a display-side AXIS stream. It adds start-of-frame (tuser) and end-of-line (tlast) markers derived from its own x/y counters, and flags any frame-length mismatch against the input tlast. It sits between the framebuffer's stream master and the display/DMA output.

## Interface
- STREAM_WIDTH, 16: input beat width; must be a multiple of PIXEL_WIDTH.
- PIXEL_WIDTH, 16: output pixel width.
- X_RESOLUTION, 128: pixels per line; must be a multiple of PPB = STREAM_WIDTH / PIXEL_WIDTH.
- Y_RESOLUTION, 128: lines per frame.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tdata  in  STREAM_WIDTH  PPB pixels; pixel 0 in the LSBs.
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- m_axis_tdata  out  PIXEL_WIDTH  pixel.
- frameError  out  1  one-cycle pulse on frame-length mismatch.

## Operation
- Two storage stages:
  - beat register: data, valid flag, slot index 0..PPB-1, captured tlast.
  - output register: m_axis_* signals.
- Slot advance:
  - Slot advances when the output register is empty or being consumed (m_axis_tready & m_axis_tvalid).
  - The pixel at the current slot moves to the output register.
- s_axis_tready = !beatValid || (slot == PPB-1 && output advancing). Beats are back-to-back with no bubbles.
- Counters:
  - x counter: 0..X_RESOLUTION-1.
  - y counter: 0..Y_RESOLUTION-1.
  - Both advance per pixel moved to the output register.
- Markers:
  - tuser = (x == 0 && y == 0).
  - tlast = (x == X_RESOLUTION-1).
- Normal end of frame: x and y both reach their maximum and the last slot of a beat carrying s_axis_tlast is reached. Counters wrap to 0 and no error is raised.
- Missing tlast: the frame count ends but the current beat has no tlast.
  - frameError pulses.
  - Counters still wrap to 0; the next pixel carries tuser.
- Early tlast: the last slot of a tlast beat is reached before the frame count ends.
  - frameError pulses.
  - That pixel is forced to tlast=1.
  - Counters reset to 0; the next pixel carries tuser.
- Both conditions cannot occur on the same pixel; at most one pulse per pixel.
- PPB == 1: slot logic degenerates and the beat register still exists. Latency and throughput are unchanged.
- Reset mid-frame: everything is cleared and any in-flight beat or pixel is discarded. The first beat after reset starts a new frame (tuser on its pixel 0).

## Timing
- Reset values:
  - s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, frameError=0.
  - Counters, slot and beatValid are 0.
- Latency: a beat accepted at edge N gives pixel 0 with m_axis_tvalid=1 after edge N+1.
- Throughput: 1 pixel/cycle sustained while m_axis_tready=1. Input duty is 1 beat per PPB cycles.
- Backpressure:
  - m_axis_* hold stable while tvalid & !tready.
  - Counters and slot freeze.
- frameError is asserted in the same cycle the offending pixel is first presented on m_axis.

## Structure
- Shared Verilog include (StreamUtil.vh) holds:
  - PPB / PPB_LOG2 computation macros.
  - The pixel-slice macro (slot * PIXEL_WIDTH +: PIXEL_WIDTH).
- Sub-module axis_output_register: a one-entry AXIS register slice with a tuser/tlast sideband. It is reused by other stream stages.
- Counters and error logic live in the top module.

## Test plan
- PPB=2, X=4, Y=2, m_axis_tready=1. Send 4 beats 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007, last beat with tlast. Required:
  - Pixels 1..8 on consecutive cycles.
  - tuser on pixel 1 only; tlast on pixels 4 and 8.
  - frameError never asserted.
- Same frame with m_axis_tready toggled 1,0,0,1 repeating:
  - Identical pixel sequence.
  - Outputs stable during stalls.
  - s_axis_tready low while the beat register is full.
- Early tlast on beat 2 (pixel 4): frameError pulses with pixel 4 (tlast=1); next beat's pixel carries tuser.
- Missing tlast on beat 4: frameError pulses with pixel 8; pixel 9 carries tuser.
- Reset asserted after pixel 3: all outputs return to reset values. The next frame's first pixel has tuser=1 and counters restart at x=0, y=0.
- PPB=1 (STREAM_WIDTH=16, PIXEL_WIDTH=16): 8 beats in, 8 pixels out. One-cycle latency, no bubbles.
